// File: rtl/pwm_cmd_dispatcher.sv
// Queues 16-bit SPI command words and issues one-cycle write strobes to PWM channels
// or the clock divider, optionally deferring PWM writes to the channel's period boundary.
module pwm_cmd_dispatcher #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned PWM_REG_WIDTH = 10,
  parameter int unsigned CLK_DIV_WIDTH = 4,
  parameter int unsigned SYNC_TIMEOUT  = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  cmd_data,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         sync_mode,
  input  logic [7:0]                   period_end,
  input  logic                         clear_err,
  output logic [7:0]                   pwm_wr,
  output logic                         clk_div_wr,
  output logic [PWM_REG_WIDTH-1:0]     wr_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         busy,
  output logic                         overflow_err,
  output logic                         bad_addr_err,
  output logic                         sync_timeout_err
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned CNT_W   = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned ENTRY_W = 4 + PWM_REG_WIDTH;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_DECODE    = 2'd1;
  localparam logic [1:0] S_WAIT_SYNC = 2'd2;
  localparam logic [1:0] S_STROBE    = 2'd3;

  if (CLK_DIV_WIDTH > PWM_REG_WIDTH) begin : g_bad_div_width
    $error("CLK_DIV_WIDTH must not exceed PWM_REG_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [ENTRY_W-1:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [LVL_W-1:0]         r_level;
  logic [ENTRY_W-1:0]       r_cmd;
  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [CNT_W-1:0]         r_sync_cnt;
  logic [CNT_W-1:0]         w_sync_cnt_nxt;
  logic [7:0]               w_pwm_wr_nxt;
  logic                     w_clk_div_wr_nxt;
  logic [PWM_REG_WIDTH-1:0] w_wr_data_nxt;
  logic                     w_bad_addr_set;
  logic                     w_timeout_set;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_overflow_set;
  logic [3:0]               w_addr;
  logic [PWM_REG_WIDTH-1:0] w_value;
  logic                     w_is_pwm;
  logic                     w_is_div;
  logic [2:0]               w_sync_ch;
  logic [7:0]               w_pwm_mask;
  logic                     w_unused_cmd_bits;

  // Bits between the address nibble and the value field are don't-care.
  assign w_unused_cmd_bits = ^cmd_data;

  assign cmd_ready      = (r_level != LVL_W'(FIFO_DEPTH));
  assign w_push         = cmd_valid && cmd_ready;
  assign w_overflow_set = cmd_valid && !cmd_ready;
  assign w_pop          = (r_state == S_IDLE) && (r_level != '0);
  assign fifo_level     = r_level;
  assign busy           = (r_level != '0) || (r_state != S_IDLE);

  assign w_addr     = r_cmd[ENTRY_W-1 -: 4];
  assign w_value    = r_cmd[PWM_REG_WIDTH-1:0];
  assign w_is_pwm   = (w_addr <= 4'd7) || (w_addr == 4'd15);
  assign w_is_div   = (w_addr == 4'd8);
  assign w_sync_ch  = (w_addr == 4'd15) ? 3'd0 : w_addr[2:0];
  assign w_pwm_mask = (w_addr == 4'd15) ? 8'hFF : (8'(1) << w_addr[2:0]);

  // Command storage; data array needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_data[15:12], cmd_data[PWM_REG_WIDTH-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
      if (w_pop)  r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
      case ({w_push, w_pop})
        2'b10:   r_level <= LVL_W'(r_level + 1'b1);
        2'b01:   r_level <= LVL_W'(r_level - 1'b1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Next-state and next-output logic for the dispatch FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_sync_cnt_nxt   = r_sync_cnt;
    w_pwm_wr_nxt     = 8'h00;
    w_clk_div_wr_nxt = 1'b0;
    w_wr_data_nxt    = wr_data;
    w_bad_addr_set   = 1'b0;
    w_timeout_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_wr_data_nxt  = w_value;
        w_sync_cnt_nxt = '0;
        if (!w_is_pwm && !w_is_div) begin
          w_bad_addr_set = 1'b1;
          w_state_nxt    = S_IDLE;
        end else if (w_is_pwm && sync_mode) begin
          w_state_nxt = S_WAIT_SYNC;
        end else begin
          w_state_nxt = S_STROBE;
        end
      end
      S_WAIT_SYNC: begin
        if (period_end[w_sync_ch]) begin
          w_state_nxt = S_STROBE;
        end else if (r_sync_cnt == CNT_W'(SYNC_TIMEOUT)) begin
          w_timeout_set = 1'b1;
          w_state_nxt   = S_STROBE;
        end else begin
          w_sync_cnt_nxt = CNT_W'(r_sync_cnt + 1'b1);
        end
      end
      S_STROBE: begin
        if (w_is_pwm) w_pwm_wr_nxt = w_pwm_mask;
        else          w_clk_div_wr_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_sync_cnt       <= '0;
      r_cmd            <= '0;
      pwm_wr           <= 8'h00;
      clk_div_wr       <= 1'b0;
      wr_data          <= '0;
      overflow_err     <= 1'b0;
      bad_addr_err     <= 1'b0;
      sync_timeout_err <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_sync_cnt       <= w_sync_cnt_nxt;
      pwm_wr           <= w_pwm_wr_nxt;
      clk_div_wr       <= w_clk_div_wr_nxt;
      wr_data          <= w_wr_data_nxt;
      if (w_pop) r_cmd <= r_mem[r_rd_ptr];
      // Sticky flags: a new event wins over clear_err.
      overflow_err     <= w_overflow_set || (overflow_err && !clear_err);
      bad_addr_err     <= w_bad_addr_set || (bad_addr_err && !clear_err);
      sync_timeout_err <= w_timeout_set  || (sync_timeout_err && !clear_err);
    end
  end

endmodule

// File: doc/pwm_cmd_dispatcher.md
Name: pwm_cmd_dispatcher

Overview:
Buffers decoded 16-bit SPI command words and turns each one into a single-cycle write strobe for one of 8 PWM channels, all PWM channels, or the clock divider. Sits between the SPI interface (data/data_rdy) and the pwm_generator / clock_divider write ports, replacing ad-hoc top-level strobe logic. Optionally defers PWM writes to the target channel's period boundary so a duty update never causes a glitched period.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, >=2
PWM_REG_WIDTH, 10, width of wr_data / PWM compare value
CLK_DIV_WIDTH, 4, divider field width; must be <= PWM_REG_WIDTH
SYNC_TIMEOUT, 1023, max cycles spent in WAIT_SYNC before forced write

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cmd_data  in  16  command word: [15:12] address, [PWM_REG_WIDTH-1:0] value
cmd_valid  in  1  single-cycle push pulse; source does not hold or retry
cmd_ready  out  1  FIFO not full
sync_mode  in  1  1 = PWM writes wait for period_end of target channel
period_end  in  8  per-channel one-cycle pulse at PWM period wrap (clk domain)
clear_err  in  1  clears sticky error flags
pwm_wr  out  8  per-channel write strobe, one cycle
clk_div_wr  out  1  clock divider write strobe, one cycle
wr_data  out  PWM_REG_WIDTH  value for the current strobe
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
busy  out  1  FIFO non-empty or FSM not IDLE
overflow_err  out  1  sticky: push while full
bad_addr_err  out  1  sticky: address 9..14 popped
sync_timeout_err  out  1  sticky: WAIT_SYNC timed out

Behaviour:
- Reset (async): FIFO emptied, FSM IDLE, pwm_wr=0, clk_div_wr=0, wr_data=0, all error flags 0, fifo_level=0, cmd_ready=1, busy=0. Reset mid-command discards the command; no strobe issued afterward.
- Push: cmd_valid && cmd_ready stores cmd_data at the edge. cmd_valid && !cmd_ready drops the word and sets overflow_err. cmd_ready = (fifo_level != FIFO_DEPTH). A pop in the same cycle does not make room for a push while full.
- FSM states: IDLE, DECODE, WAIT_SYNC, STROBE.
- IDLE: if FIFO non-empty, pop head into cmd_reg -> DECODE.
- DECODE: wr_data <= cmd_reg value bits. Decode by address:
  - 0..7 -> single channel.
  - 15 -> broadcast to all channels; sync reference is period_end[0].
  - 8 -> divider; always goes to STROBE.
  - 9..14 -> set bad_addr_err, drop command -> IDLE.
  - PWM target: sync_mode sampled here; 1 -> WAIT_SYNC (timeout counter cleared), 0 -> STROBE.
- WAIT_SYNC: counter increments each cycle. Exits -> STROBE on period_end[ch] high, or when counter == SYNC_TIMEOUT; a timeout also sets sync_timeout_err. period_end pulses arriving before WAIT_SYNC are ignored.
- STROBE: registered outputs high for exactly this one cycle, then -> IDLE:
  - pwm_wr = 1<<addr (addr 0..7) or 8'hFF (addr 15).
  - clk_div_wr for addr 8; downstream uses wr_data[CLK_DIV_WIDTH-1:0].
- wr_data is stable from the cycle after DECODE through STROBE; it holds its value after STROBE.
- Latency, sync off, empty FIFO: word pushed at edge N, strobe high in the cycle after edge N+3 (pop N+1, decode N+2, strobe N+3). Throughput: one command per 3 cycles.
- At most one strobe bit group is active per cycle; pwm_wr and clk_div_wr are never high together.
- Errors: a sticky flag sets on its event. clear_err clears all flags. Set wins over a simultaneous clear_err.
- fifo_level: push-only +1, pop-only -1, push+pop unchanged. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset, push 0x3155 with sync_mode=0 -> pwm_wr=8'h08 for exactly one cycle, 3 cycles after the push edge; wr_data=0x155; clk_div_wr stays 0.
- Push 0x8007, 0xF200, 0x0001 back-to-back -> in order: clk_div_wr with wr_data[3:0]=7; pwm_wr=8'hFF with wr_data=0x200; pwm_wr=8'h01 with wr_data=1. Strobes spaced 3 cycles apart; busy drops after the last.
- Hold dispatch in WAIT_SYNC, push 5 words with FIFO_DEPTH=4 -> cmd_ready low after the 4th, 5th word dropped, overflow_err=1. clear_err -> overflow_err=0 unless a new overflow occurs in the same cycle.
- sync_mode=1, push 0x2100, pulse period_end[2] 20 cycles later (period_end[1] pulses earlier) -> pwm_wr=8'h04 in the cycle after the period_end[2] edge; no strobe on period_end[1].
- sync_mode=1, SYNC_TIMEOUT=15, push 0x5001, no period_end -> pwm_wr=8'h20 after the timeout, sync_timeout_err=1. Push 0xA0FF -> no strobe, bad_addr_err=1.
- Assert rst while in WAIT_SYNC with 2 words queued -> all outputs 0 immediately, fifo_level=0; after release no strobe occurs.
